// File: rtl/instr_fetch_unit.sv
// Program counter / next-PC stage: selects the sequential, branch, jump or jump-register
// target and stops fetch on a halt request or an illegal fetch address. Optional macro IFU_PERF_CNT_EN adds the FetchCount port.
module instr_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter int                       MEM_DEPTH     = 100
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Stall,
    input  logic                     Branch,
    input  logic                     Jump,
    input  logic                     JumpReg,
    input  logic [ADDRESS_WIDTH-1:0] SignImm,
    input  logic [25:0]              JumpIndex,
    input  logic [ADDRESS_WIDTH-1:0] RegTarget,
    input  logic                     HaltReq,
    output logic [ADDRESS_WIDTH-1:0] InstrAddress,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]              FetchCount,
`endif
    output logic [ADDRESS_WIDTH-1:0] PCPlus4,
    output logic                     Halted,
    output logic                     FetchFault
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] PC_LIMIT = ADDRESS_WIDTH'(MEM_DEPTH * 4);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] pc, pc_nxt, npc;
    logic                     fault, fault_nxt;
    logic                     pc_load;
    logic                     npc_legal;

    assign PCPlus4 = pc + ADDRESS_WIDTH'(4);

    // Redirect priority: JumpReg > Jump > Branch > sequential (Stall handled in the FSM).
    // The jump target layout assumes a 32-bit address: 4 region bits + 26 index + 2 zero.
    always_comb begin
        npc = PCPlus4;
        if (JumpReg)
            npc = RegTarget;
        else if (Jump)
            npc = {PCPlus4[ADDRESS_WIDTH-1 -: 4], JumpIndex, 2'b00};
        else if (Branch)
            npc = PCPlus4 + {SignImm[ADDRESS_WIDTH-3:0], 2'b00};
    end

    assign npc_legal = (npc[1:0] == 2'b00) && (npc < PC_LIMIT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        fault_nxt = fault;
        pc_load   = 1'b0;
        if (state == RUN && !Stall) begin
            if (HaltReq) begin
                state_nxt = HALT;
            end else if (!npc_legal) begin
                state_nxt = HALT;
                fault_nxt = 1'b1;
            end else begin
                pc_nxt  = npc;
                pc_load = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            pc    <= RESET_VECTOR;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            fault <= fault_nxt;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST)
            FetchCount <= '0;
        else if (pc_load)
            FetchCount <= FetchCount + 32'd1;
    end
`endif

    assign InstrAddress = pc;
    assign Halted       = (state == HALT);
    assign FetchFault   = fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit plus a hand-written halt-freeze sequence.
// Checks FetchCount too when IFU_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST, Stall, Branch, Jump, JumpReg, HaltReq;
    logic [31:0] SignImm, RegTarget;
    logic [25:0] JumpIndex;
    logic [31:0] InstrAddress, PCPlus4;
    logic        Halted, FetchFault;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] FetchCount;
`endif

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.ADDRESS_WIDTH(32), .RESET_VECTOR(32'h0), .MEM_DEPTH(100)) dut (
        .CLK(CLK), .RST(RST), .Stall(Stall), .Branch(Branch), .Jump(Jump),
        .JumpReg(JumpReg), .SignImm(SignImm), .JumpIndex(JumpIndex),
        .RegTarget(RegTarget), .HaltReq(HaltReq), .InstrAddress(InstrAddress),
`ifdef IFU_PERF_CNT_EN
        .FetchCount(FetchCount),
`endif
        .PCPlus4(PCPlus4), .Halted(Halted), .FetchFault(FetchFault)
    );

    typedef struct {
        logic        rst, stall, br, j, jr, hr;
        logic [31:0] imm;
        logic [25:0] idx;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        h, f;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(logic rst, logic stall, logic br, logic j, logic jr, logic hr,
                               logic [31:0] imm, logic [25:0] idx, logic [31:0] tgt,
                               logic [31:0] pc, logic h, logic f);
        vec_t r;
        r.rst = rst; r.stall = stall; r.br = br; r.j = j; r.jr = jr; r.hr = hr;
        r.imm = imm; r.idx = idx; r.tgt = tgt; r.pc = pc; r.h = h; r.f = f;
        return r;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        RST = t.rst; Stall = t.stall; Branch = t.br; Jump = t.j; JumpReg = t.jr;
        HaltReq = t.hr; SignImm = t.imm; JumpIndex = t.idx; RegTarget = t.tgt;
    endtask

    initial begin
        logic        prev_h;
        logic [31:0] cnt_model;
        //          rst st br j  jr hr imm           idx       tgt           pc          h  f
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h4,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h8,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'hC,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h10,     0, 0));
        // backward branch: 0x14 - 8
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, 26'h0,    32'h0,        32'hC,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'h20,       32'h20,     0, 0));
        // jump beats branch
        tbl.push_back(v(0, 0, 1, 1, 0, 0, 32'h1,        26'h10,   32'h0,        32'h40,     0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'h8,        32'h8,      0, 0));
        // stall holds PC and masks halt/redirects
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h8,      0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h0,        26'h0,    32'h0,        32'h8,      0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 32'h0,        26'h5,    32'h13,       32'h8,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'hC,      0, 0));
        // JR beats Jump and Branch
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 32'h4,        26'h5,    32'h60,       32'h60,     0, 0));
        // misaligned JR target faults
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'h13,       32'h60,     1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        // JR to 400 = first illegal word
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'd400,      32'h0,      1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'd396,      32'd396,    0, 0));
        // sequential step off the end of the ROM
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'd396,    1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h4,      0, 0));
        // branch wrap: 8 + 0xFFFF_FFFC = 4, carry dropped
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 32'h3FFF_FFFF, 26'h0,    32'h0,        32'h4,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'h30,       32'h30,     0, 0));
        // halt wins over redirect; frozen afterwards
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 32'h0,        26'h0,    32'h40,       32'h30,     1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 32'h4,        26'h0,    32'h0,        32'h30,     1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 32'h0,        26'h20,   32'h0,        32'h30,     1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        26'h0,    32'h13,       32'h30,     1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        // halt beats an illegal redirect: no fault
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 32'h0,        26'h0,    32'h13,       32'h0,      1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h4,      0, 0));
        // reset during a stall
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,      0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h4,      0, 0));

        drive(tbl[0]);
        prev_h    = 1'b0;
        cnt_model = '0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            drive(tbl[i]);
            @(posedge CLK);
            #1;
            if (tbl[i].rst)
                cnt_model = '0;
            else if (!prev_h && !tbl[i].stall && !tbl[i].h)
                cnt_model = cnt_model + 1;
            prev_h = tbl[i].h;
            check("pc",     i, InstrAddress, tbl[i].pc);
            check("pcplus4", i, PCPlus4,     tbl[i].pc + 32'd4);
            check("halted", i, {31'b0, Halted},     {31'b0, tbl[i].h});
            check("fault",  i, {31'b0, FetchFault}, {31'b0, tbl[i].f});
`ifdef IFU_PERF_CNT_EN
            check("count",  i, FetchCount, cnt_model);
`endif
        end

        // Hand sequence: fault, then random stimulus must not move anything until RST.
        @(negedge CLK);
        drive(v(0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h2, 32'h0, 0, 0));
        @(posedge CLK); #1;
        check("seq_fault_pc", 100, InstrAddress, 32'h4);
        check("seq_fault",    100, {31'b0, FetchFault}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            RST = 1'b0; Stall = 1'($urandom); Branch = 1'($urandom); Jump = 1'($urandom);
            JumpReg = 1'($urandom); HaltReq = 1'($urandom);
            SignImm = 32'($urandom_range(0, 15)); JumpIndex = 26'($urandom_range(0, 20));
            RegTarget = 32'($urandom_range(0, 30)) << 2;
            @(posedge CLK); #1;
            check("seq_frozen_pc", 101 + k, InstrAddress, 32'h4);
            check("seq_frozen_h",  101 + k, {31'b0, Halted}, 32'h1);
`ifdef IFU_PERF_CNT_EN
            check("seq_frozen_cnt", 101 + k, FetchCount, cnt_model);
`endif
        end
        @(negedge CLK);
        drive(v(1, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h0, 0, 0));
        @(posedge CLK); #1;
        check("seq_rst_pc",    120, InstrAddress, 32'h0);
        check("seq_rst_h",     120, {31'b0, Halted}, 32'h0);
        check("seq_rst_fault", 120, {31'b0, FetchFault}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
